// File: rtl/wb_irq_ctrl_if.sv
// Wishbone slave bus bundle for wb_irq_ctrl.
// Master drives the request side, slave returns ack and read data.
interface wb_irq_ctrl_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: latches/masks N_SRC sources,
// drives a registered irq line and a lowest-index vector.
module wb_irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  wb_irq_ctrl_if.slave     wb,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_o
);

  logic             ack;
  logic [31:0]      dat_q;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] src_d;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_en;

  logic             req;
  logic             wr;
  logic [7:0]       addr;
  logic [N_SRC-1:0] wdat;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] status;
  logic [N_SRC-1:0] pend_next;
  logic [4:0]       vec_idx;
  logic [31:0]      rdata;
  logic             unused;

  assign req  = wb.wb_stb_i & wb.wb_cyc_i;
  assign addr = wb.wb_adr_i[7:0];
  assign wdat = wb.wb_dat_i[N_SRC-1:0];
  assign wr   = req & ack & wb.wb_we_i;

  assign wb.wb_ack_o = req & ack;
  assign wb.wb_dat_o = dat_q;

  assign rise   = src_q & ~src_d;
  assign clr    = (wr && addr == 8'h00) ? wdat : '0;
  assign status = pending & mask;

  // Edge bits: set beats clear. Level bits track src_q.
  assign pend_next = (edge_en & ((pending & ~clr) | rise))
                   | (~edge_en & src_q);

  assign unused = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i};

  // Lowest set STATUS bit wins: scan high to low.
  always_comb begin
    vec_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (status[i]) vec_idx = 5'(i);
    end
  end

  // Register read mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    unique case (addr)
      8'h00: rdata[N_SRC-1:0] = pending;
      8'h04: rdata[N_SRC-1:0] = mask;
      8'h08: rdata[N_SRC-1:0] = edge_en;
      8'h0C: rdata[N_SRC-1:0] = status;
      8'h10: rdata = {|status, 26'b0, vec_idx};
      8'h14: rdata[N_SRC-1:0] = src_q;
      default: rdata = '0;
    endcase
  end

  // Bus handshake, register writes, source pipeline and irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack     <= 1'b0;
      dat_q   <= '0;
      src_q   <= '0;
      src_d   <= '0;
      pending <= '0;
      mask    <= '0;
      edge_en <= '0;
      irq_o   <= 1'b0;
    end else begin
      ack <= req & ~ack;
      if (req && !ack) dat_q <= rdata;
      src_q   <= src_i;
      src_d   <= src_q;
      pending <= pend_next;
      irq_o   <= |status;
      if (wr && addr == 8'h04) mask    <= wdat;
      if (wr && addr == 8'h08) edge_en <= wdat;
    end
  end

endmodule
